// File: rtl/mmu_sequencer_if.sv
// Host byte / operand store / feeder signal bundle for mmu_sequencer.
// Carries weight_reload only when MMU_SEQ_WEIGHT_REUSE_EN is defined.
interface mmu_sequencer_if #(
   parameter int DATA_W = 8
);
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              mem_we;
   logic [2:0]        mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              feeder_en;
   logic [2:0]        mmu_cycle;
   logic              res_valid;
   logic [1:0]        res_idx;
   logic              busy;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
   logic              weight_reload;

   modport slave (
      input  in_valid, in_data, weight_reload,
      output in_ready, mem_we, mem_addr, mem_wdata,
             feeder_en, mmu_cycle, res_valid, res_idx, busy
   );
   modport master (
      output in_valid, in_data, weight_reload,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             feeder_en, mmu_cycle, res_valid, res_idx, busy
   );
`else
   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata,
             feeder_en, mmu_cycle, res_valid, res_idx, busy
   );
   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata,
             feeder_en, mmu_cycle, res_valid, res_idx, busy
   );
`endif
endinterface

// File: rtl/mmu_sequencer.sv
// Loads 8 operand bytes into the store, then runs one 2x2 systolic pass.
// Optional MMU_SEQ_WEIGHT_REUSE_EN: after the first pass only inputs (addr 4-7) are reloaded.
module mmu_sequencer #(
   parameter int DATA_W     = 8,
   parameter int LAST_CYCLE = 5,
   parameter int RES_FIRST  = 2
) (
   input  logic            clk,
   input  logic            rst,
   mmu_sequencer_if.slave  bus
);
   localparam logic [2:0] LAST_C  = LAST_CYCLE[2:0];
   localparam logic [2:0] FIRST_C = RES_FIRST[2:0];

   typedef enum logic {S_LOAD, S_COMPUTE} state_t;

   state_t     state_reg, state_next;
   logic [2:0] load_cnt_reg, load_cnt_next;
   logic [2:0] cycle_reg, cycle_next;
   logic       accept;
   logic [2:0] cycle_diff;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
   logic       reuse_reg, reuse_next;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= S_LOAD;
         load_cnt_reg <= 3'd0;
         cycle_reg    <= 3'd0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
         reuse_reg    <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         load_cnt_reg <= load_cnt_next;
         cycle_reg    <= cycle_next;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
         reuse_reg    <= reuse_next;
`endif
      end
   end

   always_comb begin
      state_next    = state_reg;
      load_cnt_next = load_cnt_reg;
      cycle_next    = cycle_reg;
      accept        = 1'b0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      reuse_next    = reuse_reg;
`endif
      case (state_reg)
         S_LOAD: begin
            accept = bus.in_valid;
            if (accept) begin
               if (load_cnt_reg == 3'd7) begin
                  state_next = S_COMPUTE;
                  cycle_next = 3'd0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
                  // The flag is decided on the final byte so the next load knows where to start.
                  reuse_next    = !bus.weight_reload;
                  load_cnt_next = reuse_next ? 3'd4 : 3'd0;
`else
                  load_cnt_next = 3'd0;
`endif
               end else begin
                  load_cnt_next = load_cnt_reg + 3'd1;
               end
            end
         end
         S_COMPUTE: begin
            if (cycle_reg == LAST_C) begin
               state_next = S_LOAD;
               cycle_next = 3'd0;
            end else begin
               cycle_next = cycle_reg + 3'd1;
            end
         end
         default: state_next = S_LOAD;
      endcase
   end

   assign cycle_diff    = cycle_reg - FIRST_C;
   assign bus.in_ready  = (state_reg == S_LOAD);
   // Writes are suppressed while rst is held so every output except in_ready reads 0.
   assign bus.mem_we    = accept && !rst;
   assign bus.mem_addr  = bus.mem_we ? load_cnt_reg : 3'd0;
   assign bus.mem_wdata = bus.mem_we ? bus.in_data : '0;
   assign bus.feeder_en = (state_reg == S_COMPUTE);
   assign bus.busy      = (state_reg == S_COMPUTE);
   assign bus.mmu_cycle = cycle_reg;
   assign bus.res_valid = bus.busy && (cycle_reg >= FIRST_C) && (cycle_reg <= LAST_C);
   assign bus.res_idx   = bus.res_valid ? cycle_diff[1:0] : 2'd0;
endmodule

// File: tb/tb_mmu_sequencer.sv
// Randomized scoreboard bench for mmu_sequencer: driver pushes expected writes/pass steps,
// a negedge monitor pops and compares whenever the DUT writes or computes.
module tb_mmu_sequencer;
   localparam int DATA_W = 8;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mmu_sequencer_if #(.DATA_W(DATA_W)) bus();

   mmu_sequencer #(.DATA_W(DATA_W), .LAST_CYCLE(5), .RES_FIRST(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { logic [2:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [2:0] cyc; logic rv; logic [1:0] idx; } step_t;

   wr_t   wr_q[$];
   step_t step_q[$];

   int n_checks = 0;
   int n_errors = 0;

   // reference model: next store address, weight-reuse flag, cycles left in the pass
   int m_cnt       = 0;
   bit m_reuse     = 1'b0;
   int m_busy_left = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic flag_error(input string name, input int got_val);
      n_checks++;
      n_errors++;
      $display("FAIL %s: got %0d expected nothing", name, got_val);
   endtask

   task automatic push_pass();
      step_t s;
      for (int c = 0; c <= 5; c++) begin
         s.cyc = 3'(c);
         s.rv  = (c >= 2);
         s.idx = s.rv ? 2'(c - 2) : 2'd0;
         step_q.push_back(s);
      end
   endtask

   task automatic tick();
      if (m_busy_left > 0) m_busy_left--;
   endtask

   task automatic send_byte(input logic [7:0] d, input int gap, input bit hold, input bit reload);
      int  waits;
      int  exp_wait;
      wr_t w;
      waits    = 0;
      exp_wait = m_busy_left;
      while (bus.in_ready !== 1'b1 && waits < 50) begin
         bus.in_valid = hold;
         bus.in_data  = 8'hAA;
         @(posedge clk); #1;
         waits++;
         tick();
      end
      check("ready_wait", waits, exp_wait);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      bus.weight_reload = reload;
`endif
      w.addr = 3'(m_cnt);
      w.data = d;
      wr_q.push_back(w);
      $display("byte addr=%0d data=%02h gap=%0d hold=%0d reload=%0d", m_cnt, d, gap, hold, reload);
      if (m_cnt == 7) begin
         push_pass();
         m_busy_left = 6;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
         m_reuse = !reload;
`endif
         m_cnt = m_reuse ? 4 : 0;
      end else begin
         m_cnt++;
      end
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      bus.weight_reload = 1'b0;
`endif
      repeat (gap) begin
         @(posedge clk); #1;
         tick();
      end
   endtask

   task automatic send_load(input int n, input int gap, input bit hold);
      for (int i = 0; i < n; i++)
         send_byte(8'($urandom), gap, (i == 0) ? hold : 1'b0, 1'b0);
   endtask

   // monitor: every DUT write / compute step is matched against the scoreboard queues
   int    run_len = 0;
   wr_t   mon_w;
   step_t mon_s;
   always @(negedge clk) begin
      if (rst) begin
         run_len = 0;
      end else begin
         if (bus.mem_we) begin
            check("write_in_compute", bus.feeder_en, 0);
            if (wr_q.size() == 0) begin
               flag_error("unexpected_write", int'(bus.mem_addr));
            end else begin
               mon_w = wr_q.pop_front();
               check("mem_addr", bus.mem_addr, mon_w.addr);
               check("mem_wdata", bus.mem_wdata, mon_w.data);
            end
         end
         if (bus.feeder_en) begin
            run_len++;
            check("busy", bus.busy, 1);
            check("ready_in_compute", bus.in_ready, 0);
            if (step_q.size() == 0) begin
               flag_error("unexpected_compute", int'(bus.mmu_cycle));
            end else begin
               mon_s = step_q.pop_front();
               check("mmu_cycle", bus.mmu_cycle, mon_s.cyc);
               check("res_valid", bus.res_valid, mon_s.rv);
               check("res_idx", bus.res_idx, mon_s.idx);
               if (mon_s.rv)
                  $display("result cyc=%0d idx=%0d", bus.mmu_cycle, bus.res_idx);
            end
         end else begin
            if (run_len != 0) check("pass_len", run_len, 6);
            run_len = 0;
            check("idle_res_valid", bus.res_valid, 0);
            check("idle_mmu_cycle", bus.mmu_cycle, 0);
            check("idle_busy", bus.busy, 0);
            check("idle_in_ready", bus.in_ready, 1);
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      wr_q.delete();
      step_q.delete();
      m_cnt = 0; m_reuse = 1'b0; m_busy_left = 0;
   endtask

   initial begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      bus.weight_reload = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_mem_we", bus.mem_we, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_wdata", bus.mem_wdata, 0);
      check("rst_feeder_en", bus.feeder_en, 0);
      check("rst_mmu_cycle", bus.mmu_cycle, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_idx", bus.res_idx, 0);
      check("rst_busy", bus.busy, 0);
      rst = 1'b0;

      // bytes 1..8 back-to-back
      for (int i = 1; i <= 8; i++) send_byte(8'(i), 0, 1'b0, 1'b0);
      // strobes with 2-cycle gaps
      send_load(8, 2, 1'b0);
      // in_valid held at 0xAA through COMPUTE, then the next load starts at addr 0
      send_load(8, 0, 1'b1);
      send_load(8, 0, 1'b1);

      // reset asserted mid-cycle while mmu_cycle==3
      send_load(8, 0, 1'b0);
      repeat (3) begin @(posedge clk); #1; tick(); end
      #2;
      check("pre_rst_mmu_cycle", bus.mmu_cycle, 3);
      rst = 1'b1;
      #1;
      check("async_feeder_en", bus.feeder_en, 0);
      check("async_res_valid", bus.res_valid, 0);
      check("async_busy", bus.busy, 0);
      check("async_in_ready", bus.in_ready, 1);
      $display("reset asserted at mmu_cycle 3");
      step_q.delete();
      wr_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      m_cnt = 0; m_reuse = 1'b0; m_busy_left = 0;
      send_load(8, 0, 1'b0);

      // two passes back-to-back, 9th byte on the first LOAD cycle
      send_load(16, 0, 1'b0);

`ifdef MMU_SEQ_WEIGHT_REUSE_EN
      apply_reset();
      send_load(8, 0, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(8'($urandom), 0, 1'b0, (i == 3));
      send_load(8, 0, 1'b0);
`endif

      // randomized traffic
      for (int i = 0; i < 80; i++)
         send_byte(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 3) == 0));

      repeat (12) @(posedge clk);
      #1;
      check("writes_drained", wr_q.size(), 0);
      check("passes_drained", step_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
